// File: rtl/npu_fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_fp16_pkg
// Description : Shared FP16 types and constants for the NPU datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_fp16_pkg;

    // IEEE half precision: 1 sign bit, 5 exponent bits, 10 mantissa bits
    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] man;
    } fp16_t;

    localparam logic [15:0] FP16_ZERO     = 16'h0000;
    localparam int          FP16_SIGN_BIT = 15;

endpackage
`default_nettype wire

// File: rtl/fp16_add.sv
`default_nettype none
// ============================================================================
// Module      : fp16_add
// Description : Combinational FP16 adder. Truncating alignment and rounding,
//               results with a non-positive exponent flush to zero, no NaN/Inf
//               special cases.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_add
    import npu_fp16_pkg::*;
(
    input  fp16_t a,
    input  fp16_t b,
    output fp16_t sum
);

    logic               w_a_zero;
    logic               w_b_zero;
    logic               w_swap;
    fp16_t              w_big;
    fp16_t              w_small;
    logic [4:0]         w_e_big;
    logic [4:0]         w_e_small;
    logic [10:0]        w_m_big;
    logic [10:0]        w_m_small;
    logic [4:0]         w_diff;
    logic [10:0]        w_m_shift;
    logic [11:0]        w_raw;
    logic [3:0]         w_lead;
    logic signed [6:0]  w_exp_n;
    logic [10:0]        w_norm;

    // A zero magnitude on either side passes the other operand through
    assign w_a_zero = ({a.exp, a.man} == 15'd0);
    assign w_b_zero = ({b.exp, b.man} == 15'd0);

    // Order by magnitude; raw exponent/mantissa bits compare like integers
    assign w_swap  = ({b.exp, b.man} > {a.exp, a.man});
    assign w_big   = w_swap ? b : a;
    assign w_small = w_swap ? a : b;

    // Subnormals use exponent 1 with no hidden bit
    assign w_e_big   = (w_big.exp   == 5'd0) ? 5'd1 : w_big.exp;
    assign w_e_small = (w_small.exp == 5'd0) ? 5'd1 : w_small.exp;
    assign w_m_big   = {(w_big.exp   != 5'd0), w_big.man};
    assign w_m_small = {(w_small.exp != 5'd0), w_small.man};

    // Alignment drops shifted-out bits (truncation)
    assign w_diff    = w_e_big - w_e_small;
    assign w_m_shift = w_m_small >> w_diff;

    // Big operand dominates so the difference is never negative
    assign w_raw = (w_big.sign == w_small.sign) ?
                   ({1'b0, w_m_big} + {1'b0, w_m_shift}) :
                   ({1'b0, w_m_big} - {1'b0, w_m_shift});

    // Leading-one position of the raw magnitude
    always_comb begin
        w_lead = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (w_raw[i]) begin
                w_lead = 4'(i);
            end
        end
    end

    // Hidden bit ends up at w_norm[10]; a carry-out shifts right and truncates
    assign w_exp_n = $signed({2'b00, w_e_big}) + $signed({3'b000, w_lead}) - 7'sd10;
    assign w_norm  = (w_lead == 4'd11) ? w_raw[11:1] :
                                         11'(w_raw << (4'd10 - w_lead));

    // Final result select: zero pass-through, cancellation/underflow, normal
    always_comb begin
        sum = FP16_ZERO;
        if (w_b_zero) begin
            sum = a;
        end else if (w_a_zero) begin
            sum = b;
        end else if (!w_norm[10] || (w_exp_n <= 7'sd0)) begin
            sum = FP16_ZERO;
        end else begin
            sum = {w_big.sign, w_exp_n[4:0], w_norm[9:0]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp16_add_arbiter
// Description : Round-robin arbiter feeding a two-stage pipeline around one
//               shared FP16 adder. Responses leave in acceptance order, tagged
//               with the requester index.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_add_arbiter
    import npu_fp16_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    input  logic [NUM_REQ-1:0]      req_sub,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [15:0]             resp_sum,
    output logic [ID_W-1:0]         resp_id,
    output logic                    busy
);

    // S1 operand stage
    fp16_t              r_a;
    fp16_t              r_b;
    logic [ID_W-1:0]    r_id1;
    logic               r_v1;
    // S2 result stage
    fp16_t              r_sum;
    logic [ID_W-1:0]    r_id2;
    logic               r_v2;
    // Round-robin scan start
    logic [ID_W-1:0]    r_rr_ptr;

    fp16_t              w_req_a [NUM_REQ];
    fp16_t              w_req_b [NUM_REQ];
    fp16_t              w_add_sum;
    logic               w_s2_adv;
    logic               w_s1_adv;
    logic               w_s1_free;
    logic               w_gnt_found;
    logic [ID_W-1:0]    w_gnt_id;
    logic [ID_W-1:0]    w_ptr_next;
    logic               w_accept;

    // Per-requester operand slices; subtraction flips B's sign up front
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_req_a[gi] = req_a[gi*16 +: 16];
            assign w_req_b[gi] = {req_b[gi*16 + FP16_SIGN_BIT] ^ req_sub[gi],
                                  req_b[gi*16 +: 15]};
        end
    endgenerate

    assign w_s2_adv  = !r_v2 || resp_ready;
    assign w_s1_adv  = r_v1 && w_s2_adv;
    assign w_s1_free = !r_v1 || w_s1_adv;

    // First valid requester scanning upward from the pointer, with wrap
    always_comb begin
        int idx;
        idx         = 0;
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_gnt_found && req_valid[idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = ID_W'(idx);
            end
        end
    end

    // One-hot accept, suppressed in reset and while S1 cannot take a new entry
    always_comb begin
        req_ready = '0;
        if (!rst && w_s1_free && w_gnt_found) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    assign w_accept   = |(req_valid & req_ready);
    assign w_ptr_next = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

    fp16_add u_add (
        .a   (r_a),
        .b   (r_b),
        .sum (w_add_sum)
    );

    // S1 load on accept, drain when S2 takes the entry; pointer follows grants
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_id1    <= '0;
            r_v1     <= 1'b0;
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_a      <= w_req_a[w_gnt_id];
            r_b      <= w_req_b[w_gnt_id];
            r_id1    <= w_gnt_id;
            r_v1     <= 1'b1;
            r_rr_ptr <= w_ptr_next;
        end else if (w_s1_adv) begin
            r_v1     <= 1'b0;
        end
    end

    // S2 captures the adder result; holds steady under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
            r_id2 <= '0;
            r_v2  <= 1'b0;
        end else if (w_s1_adv) begin
            r_sum <= w_add_sum;
            r_id2 <= r_id1;
            r_v2  <= 1'b1;
        end else if (r_v2 && resp_ready) begin
            r_v2  <= 1'b0;
        end
    end

    assign resp_valid = r_v2;
    assign resp_sum   = r_sum;
    assign resp_id    = r_id2;
    assign busy       = r_v1 || r_v2;

endmodule
`default_nettype wire

// File: tb/tb_fp16_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_add_arbiter
// Description : Directed self-checking bench for fp16_add_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_add_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [16*NUM_REQ-1:0]  req_a;
    logic [16*NUM_REQ-1:0]  req_b;
    logic [NUM_REQ-1:0]     req_sub;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [15:0]            resp_sum;
    logic [ID_W-1:0]        resp_id;
    logic                   busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;

    logic [15:0]     cur_exp [NUM_REQ];
    logic [ID_W-1:0] q_id  [$];
    logic [15:0]     q_sum [$];

    fp16_add_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input logic [15:0] e);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
        req_sub[i]        = s;
        cur_exp[i]        = e;
    endtask

    // Single isolated transaction with fixed two-edge latency
    task automatic do_one(input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] e);
        set_req(id, a, b, s, e);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        #1 chk("one_ready", 32'(req_ready), 32'd1 << id);
        cyc();
        req_valid = '0;
        chk("one_lat_valid", 32'(resp_valid), 32'd0);
        chk("one_busy", 32'(busy), 32'd1);
        cyc();
        chk("one_valid", 32'(resp_valid), 32'd1);
        chk("one_sum", 32'(resp_sum), 32'(e));
        chk("one_id", 32'(resp_id), 32'(id));
        cyc();
        chk("one_done", 32'(resp_valid), 32'd0);
    endtask

    // Scoreboard: accepts queue an expected result, handshakes retire them in order
    always @(negedge clk) begin
        if (rst) begin
            q_id.delete();
            q_sum.delete();
        end else begin
            if (resp_valid && resp_ready) begin
                if (q_id.size() == 0) begin
                    chk("sb_unexpected_resp", 32'(q_id.size()), 32'd1);
                end else begin
                    chk("sb_id", 32'(resp_id), 32'(q_id[0]));
                    chk("sb_sum", 32'(resp_sum), 32'(q_sum[0]));
                    void'(q_id.pop_front());
                    void'(q_sum.pop_front());
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    q_id.push_back(ID_W'(i));
                    q_sum.push_back(cur_exp[i]);
                    n_acc++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rr_sum [NUM_REQ];
        int          acc0;

        for (int i = 0; i < NUM_REQ; i++) cur_exp[i] = 16'h0000;
        rst        = 1'b1;
        resp_ready = 1'b1;
        req_valid  = '1;
        req_a      = '0;
        req_b      = '0;
        req_sub    = '0;
        cyc();
        cyc();

        // Reset state, with requests pending
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_sum", 32'(resp_sum), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);

        rst       = 1'b0;
        req_valid = '0;
        cyc();

        // Directed arithmetic, last one on requester 3 so the pointer wraps to 0
        do_one(2, 16'h3C00, 16'h3C00, 1'b0, 16'h4000);
        do_one(0, 16'h4200, 16'h3C00, 1'b1, 16'h4000);
        do_one(1, 16'h4000, 16'h4000, 1'b1, 16'h0000);
        do_one(3, 16'h0000, 16'hC500, 1'b0, 16'hC500);
        do_one(0, 16'h0400, 16'h83FF, 1'b0, 16'h0000);
        do_one(1, 16'h3C00, 16'h4000, 1'b1, 16'hBC00);
        do_one(2, 16'h3C01, 16'h3C00, 1'b0, 16'h4000);
        do_one(0, 16'hC200, 16'h0000, 1'b0, 16'hC200);
        do_one(3, 16'h3C00, 16'h1000, 1'b0, 16'h3C00);

        // Round robin under full contention, no backpressure
        set_req(0, 16'h3C00, 16'h3C00, 1'b0, 16'h4000);
        set_req(1, 16'h4000, 16'h3C00, 1'b0, 16'h4200);
        set_req(2, 16'h4200, 16'h3C00, 1'b1, 16'h4000);
        set_req(3, 16'h4400, 16'h4000, 1'b0, 16'h4600);
        rr_sum[0] = 16'h4000;
        rr_sum[1] = 16'h4200;
        rr_sum[2] = 16'h4000;
        rr_sum[3] = 16'h4600;
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            #1 chk("rr_grant", 32'(req_ready), 32'd1 << (k % 4));
            cyc();
            if (k == 0) begin
                chk("rr_fill", 32'(resp_valid), 32'd0);
            end else begin
                chk("rr_valid", 32'(resp_valid), 32'd1);
                chk("rr_id", 32'(resp_id), 32'((k - 1) % 4));
                chk("rr_sum", 32'(resp_sum), 32'(rr_sum[(k - 1) % 4]));
            end
        end
        req_valid = '0;
        cyc();
        chk("rr_tail_id", 32'(resp_id), 32'd1);
        chk("rr_tail_valid", 32'(resp_valid), 32'd1);
        cyc();
        chk("rr_empty", 32'(resp_valid), 32'd0);
        chk("rr_idle", 32'(busy), 32'd0);

        // Backpressure: pointer now at 2, only two entries fit
        resp_ready = 1'b0;
        req_valid  = '1;
        acc0       = n_acc;
        #1 chk("bp_grant0", 32'(req_ready), 32'b0100);
        cyc();
        #1 chk("bp_grant1", 32'(req_ready), 32'b1000);
        cyc();
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready_zero", 32'(req_ready), 32'd0);
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_hold_id", 32'(resp_id), 32'd2);
            chk("bp_hold_sum", 32'(resp_sum), 32'h4000);
            cyc();
        end
        chk("bp_accepts", 32'(n_acc - acc0), 32'd2);
        req_valid  = '0;
        resp_ready = 1'b1;
        cyc();
        chk("bp_drain_valid", 32'(resp_valid), 32'd1);
        chk("bp_drain_id", 32'(resp_id), 32'd3);
        chk("bp_drain_sum", 32'(resp_sum), 32'h4600);
        cyc();
        chk("bp_drained", 32'(resp_valid), 32'd0);

        // Fill both stages, then reset mid-flight
        resp_ready = 1'b0;
        req_valid  = 4'b0110;
        #1 chk("mf_grant0", 32'(req_ready), 32'b0010);
        cyc();
        #1 chk("mf_grant1", 32'(req_ready), 32'b0100);
        cyc();
        chk("mf_full_busy", 32'(busy), 32'd1);
        chk("mf_full_valid", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        #1 chk("mf_ready_in_rst", 32'(req_ready), 32'd0);
        cyc();
        rst        = 1'b0;
        req_valid  = 4'b1010;
        resp_ready = 1'b1;
        chk("mf_resp_valid", 32'(resp_valid), 32'd0);
        chk("mf_busy", 32'(busy), 32'd0);
        chk("mf_rr_ptr", 32'(dut.r_rr_ptr), 32'd0);
        #1 chk("mf_first_grant", 32'(req_ready), 32'b0010);
        cyc();
        req_valid = '0;
        cyc();
        chk("mf_resp_valid_after", 32'(resp_valid), 32'd1);
        chk("mf_resp_id_after", 32'(resp_id), 32'd1);
        chk("mf_resp_sum_after", 32'(resp_sum), 32'h4200);
        cyc();
        chk("mf_idle", 32'(busy), 32'd0);

        cyc();
        chk("sb_drained", 32'(q_id.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp16_add_arbiter.md
# fp16_add_arbiter

Round-robin arbiter and two-stage pipeline that shares one combinational FP16 adder among `NUM_REQ` requesters. Requesters are NPU lanes such as the accumulate, bias-add and residual units. Each accepted request produces exactly one response, tagged with the requester's index. Responses leave in acceptance order over a single valid/ready response channel.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `ID_W`, default 2: width of the requester index, equal to `$clog2(NUM_REQ)`.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: per-requester request valid.
- `req_ready`  out  NUM_REQ: per-requester accept; at most one bit high per cycle.
- `req_a`  in  16·NUM_REQ: operand A, FP16, slice i belongs to requester i.
- `req_b`  in  16·NUM_REQ: operand B, FP16, same slicing as `req_a`.
- `req_sub`  in  NUM_REQ: 1 means compute A − B, by inverting bit 15 of B before the adder.
- `resp_valid`  out  1: result valid.
- `resp_ready`  in  1: consumer accepts the result.
- `resp_sum`  out  16: FP16 result.
- `resp_id`  out  ID_W: index of the requester that issued the result.
- `busy`  out  1: S1 or S2 holds a valid entry.

## Operation
- **Pipeline.** S1 is the operand register: `a`, `b` (already sign-adjusted), `id`, `v1`. S2 is the result register: `sum`, `id`, `v2`. The adder sits combinationally between S1 and S2.
- **Adder semantics.**
  - Result equals A when B = 0, and B when A = 0.
  - Exact opposites give 0x0000.
  - Alignment and rounding truncate.
  - A negative result exponent gives 0x0000.
  - No NaN or Inf handling.
- **Stall logic.**
  - `s2_adv = !v2 || resp_ready`
  - `s1_adv = v1 && s2_adv`
  - `s1_free = !v1 || s1_adv`
- **Arbitration.**
  - When `s1_free` is high, grant the first requester with `req_valid` high, scanning from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
  - `req_ready[g]` is high only for the granted index g.
  - `req_ready` is combinational from `req_valid`, `rr_ptr`, `v1`, `v2` and `resp_ready`.
- **Accept.** On `req_valid[g] && req_ready[g]`:
  - S1 loads the operands and `id = g`, and `v1` is set.
  - `rr_ptr` becomes (g+1) mod `NUM_REQ`.
  - With no accept, `rr_ptr` holds.
- **Advance.**
  - On `s1_adv`: S2 loads the adder output and S1's `id`, and `v2` is set. `v1` clears unless a new accept happens in the same cycle.
  - On `resp_valid && resp_ready` with no `s1_adv`: `v2` clears.
- **Outputs.**
  - `resp_valid = v2`.
  - `resp_sum` and `resp_id` stay stable while `resp_valid && !resp_ready`.
- **Fairness.** With all requesters continuously valid and no backpressure, grants rotate 0,1,2,3,0,…
  - A requester waits at most `NUM_REQ−1` accepts between its own.
  - A requester that drops `req_valid` forfeits its turn; there is no priority inversion.
- **Simultaneous events.** In the same cycle the block can accept a new request, move S1 into S2, and retire S2. This sustains one operation per cycle.
- **Reset.**
  - `v1`, `v2`, `rr_ptr` and all data registers go to 0.
  - Hence `resp_valid`, `resp_sum`, `resp_id`, `busy` and `req_ready` are all 0 during reset.
  - On reset mid-operation, in-flight requests are discarded and produce no response.
  - `req_ready` is forced to 0 while `rst` is high.

## Timing
- Request accepted at edge T → `resp_valid` high after edge T+1 (latency 2 edges), provided S2 is free.
- Throughput: 1 result per cycle when `resp_ready` stays high.
- Backpressure:
  - With `resp_ready` low, at most 2 results are in flight (S1 + S2).
  - `req_ready` drops to all-zero in the first cycle where `v1 && v2 && !resp_ready`.
- Critical path: S1 → adder (align shifter, 11-bit add, normalize priority mux) → S2. No other logic sits on this path.

## Structure
- Shared package `npu_fp16_pkg` holds:
  - `fp16_t` (16-bit packed: sign, exp[4:0], man[9:0]).
  - Constants `FP16_ZERO = 16'h0000`, `FP16_SIGN_BIT = 15`.
- One sub-module, `fp16_add`: the combinational FP16 adder, instantiated once.
- The round-robin grant is a function or always-block within this module, not a separate sub-module.

## Test plan
- **Single request.** Requester 2 sends A=0x3C00, B=0x3C00, sub=0 → 2 edges later `resp_valid`=1, `resp_sum`=0x4000, `resp_id`=2.
- **Subtract and cancellation.**
  - Requester 0 sends 0x4200 − 0x3C00 → 0x4000.
  - Requester 1 sends 0x4000 − 0x4000 → 0x0000.
- **Round-robin under contention.** All 4 requesters held valid, `resp_ready`=1 → grants and `resp_id` sequence 0,1,2,3,0,1; one result per cycle after the 2-cycle fill.
- **Backpressure.**
  - Hold `resp_ready`=0 with continuous requests → exactly 2 accepts, then `req_ready`=0.
  - `resp_sum`/`resp_id` stay stable.
  - Release → in-order drain with no loss or duplication; a scoreboard checks every result against a reference model.
- **Reset mid-flight.** Assert `rst` for 1 cycle with S1 and S2 full → next cycle `resp_valid`=0, `busy`=0, `rr_ptr`=0; the first grant afterwards goes to the lowest valid index.
- **Zero-operand and underflow.** A=0x0000, B=0xC500 → 0xC500. A=0x0400, B=0x83FF → 0x0000 (negative exponent clamps).
